// File: rtl/divide_sequencer_pkg.sv
// Shared definitions for the iterative divider: register value type, FSM states
// and the execute-stage operation codes that route work to the divider.
`timescale 1ns/1ps
package divide_sequencer_pkg;

  typedef logic [31:0] regval_t;

  typedef enum logic [1:0] {
    Idle  = 2'd0,
    Run   = 2'd1,
    Fixup = 2'd2,
    Done  = 2'd3
  } div_state_t;

  localparam logic [3:0] DivideSigned   = 4'd6;
  localparam logic [3:0] DivideUnsigned = 4'd7;

endpackage

// File: rtl/divide_sequencer_step.sv
// One restoring-division step: shift {rem, quo} left, subtract the divisor
// magnitude when it fits and record the outcome in the quotient LSB.
`timescale 1ns/1ps
module divide_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  // One extra bit: the shifted remainder can exceed WIDTH bits for large unsigned divisors.
  logic [WIDTH:0] partial;
  logic [WIDTH:0] divisor_wide;
  logic [WIDTH:0] difference;

  assign partial      = {rem, quo[WIDTH-1]};
  assign divisor_wide = {1'b0, divisor_mag};
  assign difference   = partial - divisor_wide;

  always_comb begin
    if (partial >= divisor_wide) begin
      rem_next = difference[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = partial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/divide_sequencer.sv
// Multi-cycle signed/unsigned divider for the execute stage: magnitude restoring
// division over WIDTH cycles, followed by a sign fixup and a one-cycle done pulse.
`timescale 1ns/1ps
module divide_sequencer
  import divide_sequencer_pkg::*;
#(
  parameter int WIDTH = $bits(regval_t)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             abort,
  output logic             hold,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CountWidth = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  div_state_t state;
  div_state_t state_next;

  logic [WIDTH-1:0]      rem_q;
  logic [WIDTH-1:0]      quo_q;
  logic [WIDTH-1:0]      divisor_mag;
  logic [WIDTH-1:0]      rem_next;
  logic [WIDTH-1:0]      quo_next;
  logic [CountWidth-1:0] count;
  logic                  negate_q;
  logic                  negate_r;
  logic                  accept;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] value,
                                                 input logic             signed_op);
    return (signed_op && value[WIDTH-1]) ? -value : value;
  endfunction

  divide_step #(.WIDTH(WIDTH)) u_step (
    .rem         (rem_q),
    .quo         (quo_q),
    .divisor_mag (divisor_mag),
    .rem_next    (rem_next),
    .quo_next    (quo_next)
  );

  assign accept = (state == Idle) && start && !abort;
  assign hold   = reset_n && (accept || state == Run || state == Fixup);

  always_comb begin
    state_next = state;
    case (state)
      Idle:    if (accept) state_next = (divisor == '0) ? Done : Run;
      Run:     if (abort) state_next = Idle;
               else if (count == '0) state_next = Fixup;
      Fixup:   state_next = abort ? Idle : Done;
      Done:    state_next = Idle;
      default: state_next = Idle;
    endcase
  end

  // busy and done are registered views of the next state, so an abort suppresses both.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= Idle;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      divisor_mag <= '0;
      count       <= '0;
      negate_q    <= 1'b0;
      negate_r    <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == Run) || (state_next == Fixup);
      done  <= (state_next == Done);
      case (state)
        Idle: begin
          if (accept) begin
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= dividend;
            end else begin
              rem_q       <= '0;
              quo_q       <= magnitude(dividend, is_signed);
              divisor_mag <= magnitude(divisor, is_signed);
              negate_q    <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              negate_r    <= is_signed && dividend[WIDTH-1];
              count       <= CountWidth'(WIDTH - 1);
            end
          end
        end
        Run: begin
          if (!abort) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            count <= count - CountWidth'(1);
          end
        end
        Fixup: begin
          if (!abort) begin
            quotient  <= negate_q ? -quo_q : quo_q;
            remainder <= negate_r ? -rem_q : rem_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divide_sequencer.sv
// Scoreboard bench for divide_sequencer: directed corner cases plus random
// operations, checked against plain SystemVerilog integer division.
`timescale 1ns/1ps
module tb_divide_sequencer;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         hold;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           issued;
    int           latency;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;

  divide_sequencer #(.WIDTH(W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .abort     (abort),
    .hold      (hold),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Reference: truncating integer division in 64 bits, so the signed overflow case wraps naturally.
  function automatic exp_t model(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t   e;
    longint sa;
    longint sd;
    longint q64;
    longint r64;
    e.issued = 0;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
      e.latency = 1;
    end else begin
      if (sgn) begin
        sa = longint'($signed(a));
        sd = longint'($signed(b));
      end else begin
        sa = longint'({32'd0, a});
        sd = longint'({32'd0, b});
      end
      q64 = sa / sd;
      r64 = sa % sd;
      e.q = q64[W-1:0];
      e.r = r64[W-1:0];
      e.latency = W + 2;
    end
    return e;
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (reset_n && done) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_done", 64'(done), 64'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("quotient", 64'(quotient), 64'(e.q));
        checkOutput("remainder", 64'(remainder), 64'(e.r));
        checkOutput("latency", 64'(cycle - e.issued), 64'(e.latency));
      end
    end
  end

  task automatic waitIdle();
    int n = 0;
    while ((busy || done) && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    checkOutput("idle_wait", 64'(busy || done), 64'd0);
  endtask

  task automatic applyStimulus(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b, input bit trace);
    exp_t e;
    waitIdle();
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    e = model(sgn, a, b);
    e.issued = cycle;
    sb.push_back(e);
    if (trace) begin
      for (int k = 0; k <= e.latency; k++) begin
        @(negedge clock);
        checkOutput($sformatf("hold_k%0d", k), 64'(hold), 64'(k < e.latency));
        checkOutput($sformatf("busy_k%0d", k), 64'(busy), 64'(k >= 1 && k < e.latency && b != '0));
        @(posedge clock);
        #1;
        start = 1'b0;
      end
    end else begin
      @(posedge clock);
      #1;
      start = 1'b0;
    end
  endtask

  task automatic startRaw(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    waitIdle();
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Abort asserted during the k-th cycle after the start cycle (1..32 Run, 33 Fixup).
  task automatic applyAbort(input int at_k);
    startRaw(1'b0, $urandom, $urandom | 32'd1);
    repeat (at_k - 1) begin
      @(posedge clock);
      #1;
    end
    abort = 1'b1;
    @(posedge clock);
    #1;
    abort = 1'b0;
    checkOutput($sformatf("abort%0d_busy", at_k), 64'(busy), 64'd0);
    checkOutput($sformatf("abort%0d_done", at_k), 64'(done), 64'd0);
  endtask

  function automatic logic [W-1:0] pickOperand(input bit is_div);
    case ($urandom_range(0, 7))
      0:       return is_div ? 32'd0 : 32'h8000_0000;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #300000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    start = 1'b1;
    #12;
    checkOutput("reset_hold", 64'(hold), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_quotient", 64'(quotient), 64'd0);
    checkOutput("reset_remainder", 64'(remainder), 64'd0);
    start = 1'b0;
    #10 reset_n = 1'b1;
    @(posedge clock);
    #1;

    applyStimulus(1'b0, 32'd100, 32'd7, 1'b1);
    applyStimulus(1'b1, -32'sd7, 32'd2, 1'b0);
    applyStimulus(1'b1, 32'd7, -32'sd2, 1'b0);
    applyStimulus(1'b0, 32'h1234_5678, 32'd0, 1'b1);
    applyStimulus(1'b1, 32'h1234_5678, 32'd0, 1'b1);
    applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    applyStimulus(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    applyAbort(10);
    applyStimulus(1'b0, 32'd9, 32'd3, 1'b0);
    applyAbort(33);
    applyStimulus(1'b1, -32'sd100, -32'sd9, 1'b0);

    startRaw(1'b1, 32'hDEAD_BEEF, 32'd5);
    repeat (5) begin
      @(posedge clock);
      #1;
    end
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midrun_reset_busy", 64'(busy), 64'd0);
    checkOutput("midrun_reset_done", 64'(done), 64'd0);
    checkOutput("midrun_reset_hold", 64'(hold), 64'd0);
    checkOutput("midrun_reset_quotient", 64'(quotient), 64'd0);
    checkOutput("midrun_reset_remainder", 64'(remainder), 64'd0);
    @(posedge clock);
    #3 reset_n = 1'b1;
    @(posedge clock);
    #1;

    waitIdle();
    dividend = 32'd50;
    divisor  = 32'd3;
    start    = 1'b1;
    abort    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    abort = 1'b0;
    checkOutput("start_abort_busy", 64'(busy), 64'd0);
    checkOutput("start_abort_done", 64'(done), 64'd0);

    applyStimulus(1'b0, 32'd1000, 32'd10, 1'b0);

    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), pickOperand(1'b0), pickOperand(1'b1), 1'b0);
    end

    for (int n = 0; n < 100 && sb.size() > 0; n++) begin
      @(posedge clock);
      #1;
    end
    repeat (3) @(posedge clock);
    #1;
    checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/divide_sequencer.md
Name: divide_sequencer

Overview:
- Multi-cycle iterative divider that takes over signed and unsigned division (operations 6 and 7) from the execute stage.
- Execute hands it operands with a start pulse and holds the pipeline while it runs.
- It returns quotient and remainder together on a one-cycle done pulse.
- Divide-by-zero semantics match the combinational path: quotient is all ones.

Parameters:
WIDTH, 32, operand/result width in bits (regval_t width).

Ports:
clock  input  1  pipeline clock, rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  request a division; sampled only in Idle
is_signed  input  1  1 = operation 6 (signed), 0 = operation 7 (unsigned); sampled with start
dividend  input  WIDTH  left_value; sampled with start
divisor  input  WIDTH  adjusted_value; sampled with start
abort  input  1  pipeline flush; cancels any operation in progress
hold  output  1  combinational stall request to execute/read stages
busy  output  1  registered; high in Run and Fixup
done  output  1  registered one-cycle pulse; results valid this cycle only
quotient  output  WIDTH  result, valid while done
remainder  output  WIDTH  result, valid while done

Behaviour:
- Reset (async, reset_n low): state = Idle. busy, done, quotient, remainder and all internal registers = 0. hold = 0 while reset_n is low.
- States: Idle, Run, Fixup, Done.
- Idle:
  - start & !abort & divisor == 0: capture quotient = all ones, remainder = dividend; go to Done.
  - start & !abort & divisor != 0: latch |dividend| and |divisor| (raw operands if unsigned). Latch negate_q = is_signed & (dividend[31] ^ divisor[31]) and negate_r = is_signed & dividend[31]. Clear partial remainder, set count = WIDTH-1, go to Run.
  - abort has priority over start. abort with start leaves the block in Idle, no done.
- Run: one restoring step per cycle.
  - Shift {rem, quo} left by 1.
  - If rem_shifted >= divisor_mag, subtract it and set the quotient LSB.
  - count decrements each cycle; on the step with count == 0, go to Fixup. That is WIDTH Run cycles.
- Fixup: negate the quotient if negate_q and the remainder if negate_r (two's complement, WIDTH bits, wrap). Register to outputs, go to Done.
- Done: done = 1 for exactly this cycle; next state is Idle. A start in the Done cycle is ignored; the requester re-presents it in Idle.
- abort in Run, Fixup or Done:
  - Next state is Idle, busy drops next cycle.
  - done is suppressed: an abort arriving in the Fixup cycle prevents the Done pulse. An abort during Done does not retract the already-registered pulse.
- Latency from start (Idle cycle, nonzero divisor) to done: WIDTH+2 cycles (34 for WIDTH = 32). Zero divisor: 1 cycle.
- hold = reset_n & ((state == Idle & start & !abort) | state == Run | state == Fixup). hold is low during Done, so execute captures the results on that edge.
- Signed overflow: (-2^31) / (-1) gives quotient 0x80000000 (magnitude wrap, no negate), remainder 0. No flag is raised; execute computes flags from the returned quotient.
- Remainder sign follows the dividend. Quotient truncates toward zero, matching $signed division.
- Unsigned path never negates. Magnitude of 0x80000000 is 0x80000000, treated as unsigned WIDTH bits.

Decomposition:
- Shared package gets:
  - div_state_t enum {Idle, Run, Fixup, Done};
  - DivideSigned = 4'd6 and DivideUnsigned = 4'd7 operation constants, replacing literals in execute.
  - regval_t is reused.
- One natural sub-module: divide_step. It is combinational and takes (rem, quo, divisor_mag) to the next (rem, quo). It is instantiated once and is testable standalone.

Test Plan:
- Unsigned 100 / 7, start at cycle 0 -> hold high cycles 0..33, done at cycle 34, quotient 14, remainder 2.
- Signed -7 / 2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Signed 7 / -2 -> quotient -3, remainder 1.
- Divisor 0, dividend 0x12345678, either signedness -> done one cycle after start, quotient 0xFFFFFFFF, remainder 0x12345678, hold high only in the start cycle.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0.
- abort at Run cycle 10 -> no done pulse, busy low next cycle. Start of 9 / 3 in the following Idle cycle -> quotient 3, remainder 0 after 34 cycles.
- reset_n low mid-Run -> busy/done/quotient/remainder 0 immediately, hold 0. After release the block is in Idle and accepts a new start. Simultaneous start+abort in Idle -> stays Idle, no done.
